// File: rtl/fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_mac
// Purpose  : Time-multiplexed signed FIR filter. A single multiplier-
//            accumulator is reused over all taps, one tap per clock, with
//            valid/ready handshakes and a round-half-up, saturating output.
// Options  : FIR_COEF_LOAD_EN - adds coef_we/coef_addr/coef_wdata ports and
//            makes the coefficient bank writable while the filter is idle.
// Revision : 1.0 - initial release
// ============================================================================
module fir_serial_mac #(
  parameter int DATA_W    = 10,
  parameter int COEF_W    = 12,
  parameter int TAPS      = 8,
  parameter int FRAC_BITS = 10,
  parameter logic [TAPS*COEF_W-1:0] COEF_INIT =
    {12'sd9, 12'sd49, 12'sd168, 12'sd286, 12'sd286, 12'sd168, 12'sd49, 12'sd9}
) (
  input  logic                     clk,
  input  logic                     reset_p,
`ifdef FIR_COEF_LOAD_EN
  input  logic                     coef_we,
  input  logic [5:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
  // Half an LSB of the output, added before the arithmetic shift.
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(1 << (FRAC_BITS - 1));
  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]    SAT_HI  = (ACC_W + 1)'(OUT_MAX);
  localparam logic signed [ACC_W:0]    SAT_LO  = (ACC_W + 1)'(OUT_MIN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;

  logic                     accept;
  logic                     last_tap;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic signed [DATA_W-1:0] sat;

  assign accept   = in_valid && in_ready;
  assign last_tap = (idx == LAST_IDX);
  assign prod     = x[idx] * c[idx];
  assign sum      = acc + ACC_W'(prod);
  // One extra bit so the rounding add can never wrap.
  assign rounded  = {sum[ACC_W-1], sum} + RND;
  assign shifted  = rounded >>> FRAC_BITS;

  // Clamp the rounded result into the output sample range.
  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (shifted > SAT_HI) begin
      sat = OUT_MAX;
    end else if (shifted < SAT_LO) begin
      sat = OUT_MIN;
    end
  end

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the input-side handshake.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset_p;
        if (in_valid && !reset_p) begin
          state_next = MAC;
        end
      end
      MAC: begin
        if (last_tap) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Delay line: shifts only when a sample is accepted.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
      end
    end else if (accept) begin
      x[0] <= in_data;
      for (int i = 1; i < TAPS; i++) begin
        x[i] <= x[i-1];
      end
    end
  end

  // Accumulator, tap counter and the held output result.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= sum;
          idx <= idx + 1'b1;
          if (last_tap) begin
            out_valid <= 1'b1;
            out_data  <= sat;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIR_COEF_LOAD_EN
  logic coef_write;

  // Writes land only while idle and only for an existing tap.
  assign coef_write = coef_we && (state == IDLE) && ({1'b0, coef_addr} < 7'(TAPS));

  // Writable coefficient bank, restored to its initial contents on reset.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < TAPS; i++) begin
        c[i] <= COEF_INIT[i*COEF_W +: COEF_W];
      end
    end else if (coef_write) begin
      c[coef_addr[IDX_W-1:0]] <= coef_wdata;
    end
  end
`else
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
    assign c[gi] = COEF_INIT[gi*COEF_W +: COEF_W];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_serial_mac
// Purpose  : Self-checking bench for fir_serial_mac. A reference model
//            predicts each result when a sample is accepted; the prediction
//            is queued and compared when the DUT presents its output.
//            Coefficient-load scenarios build only with FIR_COEF_LOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_serial_mac;

  localparam int DATA_W    = 10;
  localparam int COEF_W    = 12;
  localparam int TAPS      = 8;
  localparam int FRAC_BITS = 10;

  logic                     clk       = 1'b0;
  logic                     reset_p   = 1'b1;
  logic                     in_valid  = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data   = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [DATA_W-1:0] out_data;
`ifdef FIR_COEF_LOAD_EN
  logic                     coef_we    = 1'b0;
  logic [5:0]               coef_addr  = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
`endif

  fir_serial_mac #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk       (clk),
    .reset_p   (reset_p),
`ifdef FIR_COEF_LOAD_EN
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int hist[TAPS];
  int coef[TAPS];
  int acc_cyc = 0;

  // Reference filter: shift in one sample, return the rounded, saturated sum.
  function automatic int model_step(int d);
    longint s;
    longint r;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(hist[i]) * longint'(coef[i]);
    r = (s + (longint'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
    if (r > 511)  r = 511;
    if (r < -512) r = -512;
    return int'(r);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    exp_q.delete();
  endfunction

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -99999;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample, wait for its result, complete the handshake if out_ready.
  task automatic run_one(input int d, output bit ok, output int lat, output int got);
    bit rdy;
    ok = 1'b0; lat = -1; got = 0; rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready === 1'b1) begin rdy = 1'b1; break; end
      tick();
    end
    if (!rdy) return;
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    tick();
    in_valid = 1'b0;
    acc_cyc  = cyc;
    exp_q.push_back(model_step(d));
    for (int i = 0; i < 200; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1; lat = cyc - acc_cyc; got = int'(out_data);
        break;
      end
      tick();
    end
    if (ok && out_ready) tick();
  endtask

  // Push zeros through so the next scenario starts from an empty history.
  task automatic flush_history();
    bit ok; int lat; int got; int e;
    for (int k = 0; k < TAPS; k++) begin
      run_one(0, ok, lat, got);
      e = pop_exp();
    end
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    reset_p = 1'b0;
    model_clear();
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_impulse(input string tag);
    int imp[TAPS] = '{2, 12, 42, 72, 72, 42, 12, 2};
    bit ok; int lat; int got; int e;
    for (int k = 0; k < TAPS; k++) begin
      run_one((k == 0) ? 256 : 0, ok, lat, got);
      e = pop_exp();
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_timeout[%0d] got=%b want=1", tag, k, ok); end
      n_checks++; if (lat !== TAPS) begin n_fail++; $display("FAIL %s_latency[%0d] got=%0d want=%0d", tag, k, lat, TAPS); end
      n_checks++; if (got !== imp[k]) begin n_fail++; $display("FAIL %s_const[%0d] got=%0d want=%0d", tag, k, got, imp[k]); end
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL %s_model[%0d] got=%0d want=%0d", tag, k, got, e); end
    end
  endtask

  task automatic test_step();
    bit ok; int lat; int got; int e; int prev;
    prev = -1;
    for (int k = 0; k < 12; k++) begin
      run_one(400, ok, lat, got);
      e = pop_exp();
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL step_timeout[%0d] got=%b want=1", k, ok); end
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL step_model[%0d] got=%0d want=%0d", k, got, e); end
      if (k >= 7) begin
        n_checks++; if (got !== 400) begin n_fail++; $display("FAIL step_settled[%0d] got=%0d want=400", k, got); end
      end
      if (prev >= 0) begin
        n_checks++; if (acc_cyc - prev !== TAPS + 2) begin n_fail++; $display("FAIL step_throughput[%0d] got=%0d want=%0d", k, acc_cyc - prev, TAPS + 2); end
      end
      prev = acc_cyc;
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; int got; int e;
    logic signed [DATA_W-1:0] held;
    out_ready = 1'b0;
    run_one(100, ok, lat, got);
    e = pop_exp();
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b want=1", ok); end
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL bp_model got=%0d want=%0d", got, e); end
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom_range(0, 1023));
      tick();
      n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL bp_hold[%0d] got=%0d want=%0d", k, out_data, held); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b want=1", k, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b want=0", k, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b want=0", out_valid); end
    n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL bp_data_kept got=%0d want=%0d", out_data, held); end
    run_one(-300, ok, lat, got);
    e = pop_exp();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL bp_history got=%0d want=%0d", got, e); end
    run_one(0, ok, lat, got);
    e = pop_exp();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL bp_history2 got=%0d want=%0d", got, e); end
  endtask

  task automatic test_reset_mid_mac();
    bit seen;
    for (int i = 0; i < 100 && in_ready !== 1'b1; i++) tick();
    in_valid = 1'b1;
    in_data  = DATA_W'(256);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset_p = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b want=0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_hold_in_ready got=%b want=0", in_ready); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_hold_data got=%0d want=0", out_data); end
    reset_p = 1'b0;
    model_clear();
    seen = 1'b0;
    for (int i = 0; i < TAPS + 4; i++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_partial_result got=%b want=0", seen); end
    test_impulse("imp_after_reset");
  endtask

`ifdef FIR_COEF_LOAD_EN
  task automatic test_coef_gating();
    bit ok; int got; int e;
    flush_history();
    for (int i = 0; i < 100 && in_ready !== 1'b1; i++) tick();
    in_valid = 1'b1;
    in_data  = '0;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model_step(0));
    coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = '0;
    tick(); tick(); tick();
    coef_we = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    got = int'(out_data);
    tick();
    e = pop_exp();
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL gate_timeout got=%b want=1", ok); end
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL gate_mac_out got=%0d want=%0d", got, e); end
    coef_we = 1'b1; coef_addr = 6'd9; coef_wdata = '0;
    tick();
    coef_we = 1'b0;
    flush_history();
    test_impulse("imp_after_gated_writes");
  endtask

  task automatic test_saturation();
    bit ok; int lat; int got; int e;
    for (int i = 0; i < TAPS; i++) begin
      coef_we = 1'b1; coef_addr = 6'(i); coef_wdata = 12'sd2047;
      tick();
      coef[i] = 2047;
    end
    coef_we = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      run_one(511, ok, lat, got);
      e = pop_exp();
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL sat_pos_model[%0d] got=%0d want=%0d", k, got, e); end
    end
    n_checks++; if (got !== 511) begin n_fail++; $display("FAIL sat_pos got=%0d want=511", got); end
    for (int k = 0; k < TAPS; k++) begin
      run_one(-512, ok, lat, got);
      e = pop_exp();
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL sat_neg_model[%0d] got=%0d want=%0d", k, got, e); end
    end
    n_checks++; if (got !== -512) begin n_fail++; $display("FAIL sat_neg got=%0d want=-512", got); end
  endtask
`endif

  initial begin
    coef = '{9, 49, 168, 286, 286, 168, 49, 9};
    model_clear();
    test_reset();
    test_impulse("impulse");
    test_step();
    test_backpressure();
    test_reset_mid_mac();
`ifdef FIR_COEF_LOAD_EN
    test_coef_gating();
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
